pixel_streamer: RTL
===================

# pixel_streamer

Raster-order pixel source for the Canny front end. It reads one frame from a synchronous-read frame memory and emits it one pixel per cycle on a valid/ready stream, which drives `pixel_in`/`pixel_in_valid` of `pixel_loader`. It replaces the bench-side file driver in system builds. Start-of-line and end-of-frame markers are provided for downstream framing.

## Interface
- `IMG_W`, 512, pixels per row (≥2)
- `IMG_H`, 512, rows per frame (≥2)
- `PIX_W`, 8, pixel width
- `ADDR_W`, 18, frame-memory address width; IMG_W*IMG_H ≤ 2**ADDR_W
- `clk`  in  1  clock; all logic rising-edge
- `rstN`  in  1  reset, asynchronous, active-low
- `start`  in  1  begin frame; sampled only in IDLE
- `abort`  in  1  synchronous flush to IDLE; no `done`
- `busy`  out  1  high from the cycle after `start` acceptance until `done`/abort
- `done`  out  1  one-cycle pulse after the last pixel handshake
- `mem_rd_en`  out  1  read strobe
- `mem_addr`  out  ADDR_W  read address, row*IMG_W+col
- `mem_rd_data`  in  PIX_W  valid the cycle after `mem_rd_en`
- `pixel_out`  out  PIX_W  stream data
- `pixel_out_valid`  out  1  stream valid
- `pixel_out_ready`  in  1  stream ready; tie high for `pixel_loader`
- `pixel_out_sol`  out  1  qualifies `pixel_out` as column 0
- `pixel_out_eof`  out  1  qualifies `pixel_out` as the last pixel of the frame

## Operation
- FSM states: IDLE, RUN, DRAIN.
  - IDLE → RUN on `start`.
  - RUN → DRAIN when the read of address IMG_W*IMG_H−1 is issued.
  - DRAIN → IDLE on the handshake of the eof pixel; `done` pulses the following cycle.
- Read address counter runs 0 … IMG_W*IMG_H−1. Separate col/row counters track the output side for sol/eof, and wrap col at IMG_W−1.
- Output buffer is a 2-entry FIFO. An in-flight flag covers the 1-cycle memory latency, and `mem_rd_data` is written into the FIFO the cycle after `mem_rd_en`.
- Read issue rule: issue in RUN iff occupancy + inflight − pop < 2, where pop = `pixel_out_valid & pixel_out_ready`. This never overflows and sustains 1 pixel/cycle with ready held high.
- `pixel_out`/`pixel_out_valid`/`sol`/`eof` come from the FIFO head and are held stable while valid & !ready.
- `start` while busy: ignored.
- `abort` in any state: next cycle is IDLE, FIFO emptied, in-flight data discarded, counters zeroed, no `done`. Abort has priority over a simultaneous handshake.
- `start` and `abort` in the same IDLE cycle: abort wins, and the FSM stays in IDLE.

## Timing
- Reset values: `busy`=0, `done`=0, `mem_rd_en`=0, `mem_addr`=0, `pixel_out`=0, `pixel_out_valid`=0, `sol`=0, `eof`=0. FSM resets to IDLE, FIFO to empty, inflight to 0.
- Reset mid-frame has the same effect as abort, applied asynchronously.
- `start` sampled high at edge N:
  - `busy` and `mem_rd_en` (addr 0) high after N.
  - pixel 0 `pixel_out_valid` high after N+2.
- With ready held high, the frame ends at edge N+2+IMG_W*IMG_H, where the eof handshake completes. `done` is high for the single cycle after that edge, and `busy` drops in the same cycle.
- Ready low for k cycles stalls the output by exactly k cycles, with no lost or duplicated pixels.

## Structure
- `canny_pkg` holds the shared image constants (IMG_W, IMG_H, PIX_W), `typedef logic [PIX_W-1:0] pixel_t`, and the FSM state enum.
- One sub-module, `pixel_skid_fifo`: a 2-entry FIFO with push/pop, occupancy, and a synchronous flush. It carries data plus the sol/eof bits.

## Test plan
- IMG_W=4, IMG_H=3, memory[i]=i+16, ready=1:
  - `pixel_out` is 16…27 on consecutive cycles, first valid 3 cycles after `start`.
  - `sol` on 16, 20, 24; `eof` on 27; one `done` pulse.
- Same image, ready toggled 1,0,0,1 repeating: sequence is intact, no duplicates, and data is held stable while stalled.
- Full 512×512 frame, memory[i]=i[7:0], ready=1: 262144 handshakes, eof on the last, and `done` at start+262146 cycles.
- `start` pulsed again mid-frame: ignored; output identical to a single start.
- `abort` after 5 pixels: `pixel_out_valid` low the next cycle, no `done`. A subsequent `start` restarts from pixel 16 (IMG_W=4 case).
- `rstN` low mid-frame with ready low and the FIFO full: all outputs zero immediately. Next frame after release is correct from address 0.

Source files
------------

// File: rtl/canny_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// canny_pkg : shared image geometry, pixel type and streamer FSM encoding
// Rev 1.0
// ---------------------------------------------------------------------------
package canny_pkg;
  localparam int IMG_W  = 512;
  localparam int IMG_H  = 512;
  localparam int PIX_W  = 8;
  localparam int ADDR_W = 18;

  typedef logic [PIX_W-1:0] pixel_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } stream_state_e;
endpackage
`default_nettype wire

// File: rtl/pixel_streamer_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pixel_streamer_if : frame-memory read port plus valid/ready pixel stream
// Rev 1.0
// ---------------------------------------------------------------------------
interface pixel_streamer_if #(
  parameter int PIX_W  = canny_pkg::PIX_W,
  parameter int ADDR_W = canny_pkg::ADDR_W
) ();
  logic [PIX_W-1:0]  pixel_out;
  logic              pixel_out_valid;
  logic              pixel_out_ready;
  logic              pixel_out_sol;
  logic              pixel_out_eof;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [PIX_W-1:0]  mem_rd_data;

  modport master (
    output pixel_out, pixel_out_valid, pixel_out_sol, pixel_out_eof,
    output mem_rd_en, mem_addr,
    input  pixel_out_ready, mem_rd_data
  );

  modport slave (
    input  pixel_out, pixel_out_valid, pixel_out_sol, pixel_out_eof,
    input  mem_rd_en, mem_addr,
    output pixel_out_ready, mem_rd_data
  );
endinterface
`default_nettype wire

// File: rtl/pixel_skid_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pixel_skid_fifo : 2-entry FIFO carrying pixel data with sol/eof tags
// Rev 1.0
// ---------------------------------------------------------------------------
module pixel_skid_fifo #(
  parameter int DW = 8
) (
  input  wire logic          clk,
  input  wire logic          rstN,
  input  wire logic          i_flush,
  input  wire logic          i_push,
  input  wire logic [DW-1:0] i_data,
  input  wire logic          i_sol,
  input  wire logic          i_eof,
  input  wire logic          i_pop,
  output logic [DW-1:0]      o_data,
  output logic               o_sol,
  output logic               o_eof,
  output logic               o_valid,
  output logic [1:0]         o_count
);
  logic [DW+1:0] r_ent0;
  logic [DW+1:0] r_ent1;
  logic          r_wr_ptr;
  logic          r_rd_ptr;
  logic [1:0]    r_count;
  logic          w_push;
  logic          w_pop;
  logic [DW+1:0] w_head;

  assign w_pop   = i_pop && (r_count != 2'd0);
  assign w_push  = i_push && ((r_count != 2'd2) || w_pop);
  assign w_head  = r_rd_ptr ? r_ent1 : r_ent0;
  assign {o_sol, o_eof, o_data} = w_head;
  assign o_valid = (r_count != 2'd0);
  assign o_count = r_count;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_ent0   <= '0;
      r_ent1   <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else if (i_flush) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        if (r_wr_ptr) r_ent1 <= {i_sol, i_eof, i_data};
        else          r_ent0 <= {i_sol, i_eof, i_data};
        r_wr_ptr <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: rtl/pixel_streamer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pixel_streamer : raster-order frame reader emitting one pixel per cycle
// Rev 1.0
// ---------------------------------------------------------------------------
module pixel_streamer #(
  parameter int IMG_W  = canny_pkg::IMG_W,
  parameter int IMG_H  = canny_pkg::IMG_H,
  parameter int PIX_W  = canny_pkg::PIX_W,
  parameter int ADDR_W = canny_pkg::ADDR_W
) (
  input  wire logic        clk,
  input  wire logic        rstN,
  input  wire logic        start,
  input  wire logic        abort,
  output logic             busy,
  output logic             done,
  pixel_streamer_if.master bus
);
  import canny_pkg::*;

  localparam int NPIX = IMG_W * IMG_H;
  localparam int CW   = $clog2(IMG_W);
  localparam int RW   = $clog2(IMG_H);
  localparam logic [ADDR_W-1:0] c_ADDR_LAST = ADDR_W'(NPIX - 1);
  localparam logic [CW-1:0]     c_COL_LAST  = CW'(IMG_W - 1);
  localparam logic [RW-1:0]     c_ROW_LAST  = RW'(IMG_H - 1);

  stream_state_e     r_state;
  stream_state_e     w_state_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic              r_inflight;
  logic              r_done;
  logic [CW-1:0]     r_col;
  logic [RW-1:0]     r_row;
  logic              w_busy;
  logic              w_run;
  logic              w_issue;
  logic              w_pop;
  logic              w_last_pop;
  logic              w_push_sol;
  logic              w_push_eof;
  logic [1:0]        w_count;
  logic [2:0]        w_level;
  logic [PIX_W-1:0]  w_head_data;
  logic              w_head_sol;
  logic              w_head_eof;
  logic              w_head_valid;

  // Slots already committed (stored + arriving) must stay below 2 after this cycle's pop.
  assign w_level    = {1'b0, w_count} + {2'b00, r_inflight};
  assign w_pop      = w_head_valid && bus.pixel_out_ready;
  assign w_issue    = w_run && !abort && (w_level < (3'd2 + {2'b00, w_pop}));
  assign w_last_pop = (r_state == ST_DRAIN) && w_pop && w_head_eof;
  assign w_push_sol = (r_col == '0);
  assign w_push_eof = (r_col == c_COL_LAST) && (r_row == c_ROW_LAST);

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (abort) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:  if (start) w_state_nxt = ST_RUN;
        ST_RUN:   if (w_issue && (r_addr == c_ADDR_LAST)) w_state_nxt = ST_DRAIN;
        ST_DRAIN: if (w_last_pop) w_state_nxt = ST_IDLE;
        default:  w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    w_busy = (r_state != ST_IDLE);
    w_run  = (r_state == ST_RUN);
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_addr     <= '0;
      r_inflight <= 1'b0;
      r_col      <= '0;
      r_row      <= '0;
      r_done     <= 1'b0;
    end else if (abort) begin
      r_addr     <= '0;
      r_inflight <= 1'b0;
      r_col      <= '0;
      r_row      <= '0;
      r_done     <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      r_done     <= w_last_pop;
      if (w_issue) r_addr <= (r_addr == c_ADDR_LAST) ? '0 : r_addr + ADDR_W'(1);
      // Position counters follow the data entering the FIFO, so tags ride with each pixel.
      if (r_inflight) begin
        if (r_col == c_COL_LAST) begin
          r_col <= '0;
          r_row <= (r_row == c_ROW_LAST) ? '0 : r_row + RW'(1);
        end else begin
          r_col <= r_col + CW'(1);
        end
      end
    end
  end

  pixel_skid_fifo #(
    .DW(PIX_W)
  ) u_fifo (
    .clk     (clk),
    .rstN    (rstN),
    .i_flush (abort),
    .i_push  (r_inflight),
    .i_data  (bus.mem_rd_data),
    .i_sol   (w_push_sol),
    .i_eof   (w_push_eof),
    .i_pop   (w_pop),
    .o_data  (w_head_data),
    .o_sol   (w_head_sol),
    .o_eof   (w_head_eof),
    .o_valid (w_head_valid),
    .o_count (w_count)
  );

  assign busy                = w_busy;
  assign done                = r_done;
  assign bus.mem_rd_en       = w_issue;
  assign bus.mem_addr        = r_addr;
  assign bus.pixel_out       = w_head_data;
  assign bus.pixel_out_valid = w_head_valid;
  assign bus.pixel_out_sol   = w_head_sol;
  assign bus.pixel_out_eof   = w_head_eof;
endmodule
`default_nettype wire
